// File: rtl/pdm_stream_tx.sv
// pdm_stream_tx: AXI-Stream PCM sample sink driving a first-order PDM line.
// A one-entry holding buffer decouples the stream handshake from the
// modulator, which reloads its current sample once every OSR bit periods.
module pdm_stream_tx #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 50,
  parameter int unsigned OSR     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic              pdm_clk,
  output logic              pdm_out,
  output logic              sample_strobe,
  output logic              underrun
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] cur;
  logic              hold_valid;

  logic              tick;
  logic              load;
  logic              take;
  logic              hold_valid_nxt;
  logic [DATA_W-1:0] eff;
  logic [DATA_W-1:0] u;
  logic [DATA_W:0]   sum;

  // Tick/load decode, effective sample selection and modulator adder.
  always_comb begin
    tick = enable && (div_cnt == DIV_LAST);
    load = tick && (bit_cnt == '0);
    take = s_axis_tvalid && s_axis_tready;

    eff = cur;
    if (load) begin
      eff = hold_valid ? hold : '0;
    end

    // Offset binary: midscale PCM (0) maps to half-full accumulator step.
    u   = {~eff[DATA_W-1], eff[DATA_W-2:0]};
    sum = {1'b0, acc} + {1'b0, u};

    // tready=1 implies hold_valid=0, so take and a buffered load never coincide.
    hold_valid_nxt = hold_valid;
    if (load) begin
      hold_valid_nxt = 1'b0;
    end
    if (take) begin
      hold_valid_nxt = 1'b1;
    end
  end

  // One-entry holding buffer and registered ready; runs regardless of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold          <= '0;
      hold_valid    <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      if (take) begin
        hold <= s_axis_tdata;
      end
      hold_valid    <= hold_valid_nxt;
      s_axis_tready <= ~hold_valid_nxt;
    end
  end

  // Bit-clock divider, 50% duty pdm_clk, and per-sample bit counter.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        pdm_clk <= 1'b1;
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end else if (div_cnt == DIV_HALF) begin
        pdm_clk <= 1'b0;
      end
    end
  end

  // First-order modulator: the adder carry is the PDM bit; sample reload at boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc           <= '0;
      cur           <= '0;
      pdm_out       <= 1'b0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_strobe <= load;
      if (!enable) begin
        acc     <= '0;
        pdm_out <= 1'b0;
      end else if (tick) begin
        acc     <= sum[DATA_W-1:0];
        pdm_out <= sum[DATA_W];
      end
      if (load) begin
        cur <= hold_valid ? hold : '0;
        if (!hold_valid) begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_stream_tx.sv
// tb_pdm_stream_tx: directed scenarios for pdm_stream_tx with CLK_DIV=4, OSR=8.
`timescale 1ns/1ps
module tb_pdm_stream_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        pdm_clk;
  logic        pdm_out;
  logic        sample_strobe;
  logic        underrun;

  int n_cmp = 0;
  int n_bad = 0;

  pdm_stream_tx #(
    .DATA_W  (16),
    .CLK_DIV (4),
    .OSR     (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .pdm_clk       (pdm_clk),
    .pdm_out       (pdm_out),
    .sample_strobe (sample_strobe),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  // Observation: PDM bits at each pdm_clk rise, strobe times, accepted samples.
  int          cyc = 0;
  logic        prev_pdm_clk = 1'b0;
  logic        bits[$];
  int          rise_t[$];
  int          strobe_t[$];
  logic [15:0] accepted[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pdm_clk && !prev_pdm_clk) begin
      bits.push_back(pdm_out);
      rise_t.push_back(cyc);
    end
    prev_pdm_clk = pdm_clk;
    if (sample_strobe) strobe_t.push_back(cyc);
    if (s_axis_tvalid && s_axis_tready && !reset) accepted.push_back(s_axis_tdata);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bits.delete();
    rise_t.delete();
    strobe_t.delete();
    accepted.delete();
  endtask

  task automatic restart();
    reset = 1'b1;
    enable = 1'b0;
    s_axis_tvalid = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    clear_mon();
  endtask

  function automatic logic [15:0] seq(input int i);
    case (i)
      0:       return 16'h8000;
      1:       return 16'h0000;
      2:       return 16'h4000;
      default: return 16'(32'h8000 + i - 2);
    endcase
  endfunction

  int idx;

  task automatic feed_cycle();
    logic hs;
    hs = s_axis_tvalid && s_axis_tready;
    cycle();
    if (hs) begin
      idx++;
      s_axis_tdata = seq(idx);
    end
  endtask

  task automatic test_reset();
    logic seen;
    reset = 1'b1; enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    repeat (3) cycle();
    n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
    n_cmp++; if (pdm_clk !== 1'b0) begin n_bad++; $display("FAIL reset_pdm_clk: got %b want 0", pdm_clk); end
    n_cmp++; if (pdm_out !== 1'b0) begin n_bad++; $display("FAIL reset_pdm_out: got %b want 0", pdm_out); end
    n_cmp++; if (sample_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", sample_strobe); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    reset = 1'b0;
    n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL release_tready_early: got %b want 0", s_axis_tready); end
    cycle();
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL release_tready: got %b want 1", s_axis_tready); end
    seen = 1'b0;
    repeat (12) begin cycle(); seen = seen | (pdm_clk !== 1'b0); end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL idle_pdm_clk: toggled=%b want 0", seen); end
  endtask

  task automatic test_midscale();
    int bad;
    restart();
    s_axis_tdata = 16'h0000; s_axis_tvalid = 1'b1;
    repeat (2) cycle();
    clear_mon();
    enable = 1'b1;
    repeat (8 * 32 + 8) cycle();
    bad = 0;
    for (int i = 0; i < 64; i++) if (bits[i] !== 1'(i % 2)) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL midscale_pattern: %0d bits wrong, want 0", bad); end
    n_cmp++; if (rise_t[1] - rise_t[0] != 4) begin n_bad++; $display("FAIL midscale_period: got %0d want 4", rise_t[1] - rise_t[0]); end
    n_cmp++; if (rise_t[20] - rise_t[19] != 4) begin n_bad++; $display("FAIL midscale_period_late: got %0d want 4", rise_t[20] - rise_t[19]); end
    bad = 0;
    if (strobe_t.size() < 8) bad = 99;
    else for (int i = 1; i < 8; i++) if (strobe_t[i] - strobe_t[i-1] != 32) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL midscale_strobe_spacing: %0d bad of %0d strobes, want 0", bad, strobe_t.size()); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL midscale_underrun: got %b want 0", underrun); end
    enable = 1'b0;
  endtask

  task automatic test_density();
    logic [15:0] vals[3];
    logic        exp_b;
    int          bad;
    vals[0] = 16'h4000; vals[1] = 16'h8000; vals[2] = 16'h7FFF;
    for (int k = 0; k < 3; k++) begin
      restart();
      s_axis_tdata = vals[k]; s_axis_tvalid = 1'b1;
      repeat (2) cycle();
      clear_mon();
      enable = 1'b1;
      repeat (64 * 4 + 8) cycle();
      bad = 0;
      for (int i = 0; i < 64; i++) begin
        case (k)
          0:       exp_b = (i % 4) != 0;
          1:       exp_b = 1'b0;
          default: exp_b = i != 0;
        endcase
        if (bits[i] !== exp_b) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL density_%h: %0d bits wrong, want 0", vals[k], bad); end
      enable = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int   tready_hi;
    int   bad;
    logic exp_b;
    restart();
    idx = 0; s_axis_tdata = seq(0); s_axis_tvalid = 1'b1;
    repeat (2) feed_cycle();
    enable = 1'b1;
    tready_hi = 0;
    for (int i = 0; i < 192; i++) begin
      feed_cycle();
      if (s_axis_tready === 1'b1) tready_hi++;
    end
    n_cmp++; if (tready_hi != 6) begin n_bad++; $display("FAIL b2b_tready_cycles: got %0d want 6", tready_hi); end
    n_cmp++; if (accepted.size() != 7) begin n_bad++; $display("FAIL b2b_handshakes: got %0d want 7", accepted.size()); end
    bad = 0;
    for (int i = 0; i < 7; i++) if (accepted[i] !== seq(i)) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL b2b_sequence: %0d samples wrong, want 0", bad); end
    n_cmp++; if (strobe_t.size() != 6) begin n_bad++; $display("FAIL b2b_strobes: got %0d want 6", strobe_t.size()); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 8)       exp_b = 1'b0;
      else if (i < 16) exp_b = 1'(i % 2);
      else if (i < 24) exp_b = ((i - 16) % 4) != 0;
      else             exp_b = 1'b0;
      if (bits[i] !== exp_b) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL b2b_bits: %0d bits wrong, want 0", bad); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL b2b_underrun: got %b want 0", underrun); end
    enable = 1'b0; s_axis_tvalid = 1'b0;
  endtask

  task automatic test_underrun();
    logic u67, u68;
    int   bad;
    restart();
    s_axis_tdata = 16'h8000; s_axis_tvalid = 1'b1;
    repeat (2) cycle();
    enable = 1'b1;
    u67 = 1'bx; u68 = 1'bx;
    for (int i = 1; i <= 140; i++) begin
      cycle();
      if (accepted.size() >= 2) s_axis_tvalid = 1'b0;
      if (i == 67) u67 = underrun;
      if (i == 68) u68 = underrun;
    end
    n_cmp++; if (accepted.size() != 2) begin n_bad++; $display("FAIL underrun_accepted: got %0d want 2", accepted.size()); end
    n_cmp++; if (u67 !== 1'b0) begin n_bad++; $display("FAIL underrun_early: got %b want 0", u67); end
    n_cmp++; if (u68 !== 1'b1) begin n_bad++; $display("FAIL underrun_rise: got %b want 1", u68); end
    bad = 0;
    for (int i = 0; i < 32; i++) if (bits[i] !== ((i < 16) ? 1'b0 : 1'(i % 2))) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL underrun_bits: %0d bits wrong, want 0", bad); end
    s_axis_tdata = 16'h8000; s_axis_tvalid = 1'b1;
    repeat (40) cycle();
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
    reset = 1'b1;
    cycle();
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL underrun_reset: got %b want 0", underrun); end
    reset = 1'b0; enable = 1'b0; s_axis_tvalid = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic seen;
    int   ns;
    int   bad;
    logic s3, s4;
    restart();
    s_axis_tdata = 16'h4000; s_axis_tvalid = 1'b1;
    repeat (2) cycle();
    enable = 1'b1;
    repeat (13) cycle();
    n_cmp++; if (pdm_clk !== 1'b1) begin n_bad++; $display("FAIL drop_pre_clk: got %b want 1", pdm_clk); end
    n_cmp++; if (pdm_out !== 1'b1) begin n_bad++; $display("FAIL drop_pre_out: got %b want 1", pdm_out); end
    enable = 1'b0;
    cycle();
    n_cmp++; if (pdm_clk !== 1'b0) begin n_bad++; $display("FAIL drop_clk: got %b want 0", pdm_clk); end
    n_cmp++; if (pdm_out !== 1'b0) begin n_bad++; $display("FAIL drop_out: got %b want 0", pdm_out); end
    ns = strobe_t.size();
    seen = 1'b0;
    repeat (10) begin cycle(); seen = seen | (pdm_clk !== 1'b0); end
    n_cmp++; if (seen !== 1'b0 || strobe_t.size() != ns) begin n_bad++; $display("FAIL drop_idle: clk_toggled=%b strobes=%0d want 0 and %0d", seen, strobe_t.size(), ns); end
    bits.delete();
    enable = 1'b1;
    repeat (3) cycle();
    s3 = sample_strobe;
    cycle();
    s4 = sample_strobe;
    n_cmp++; if (s3 !== 1'b0 || s4 !== 1'b1) begin n_bad++; $display("FAIL reenable_strobe: got %b%b want 01", s3, s4); end
    repeat (20) cycle();
    bad = 0;
    for (int i = 0; i < 4; i++) if (bits[i] !== (i != 0)) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL reenable_bits: %0d bits wrong, want 0", bad); end
    enable = 1'b0; s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    restart();
    s_axis_tdata = 16'h4000; s_axis_tvalid = 1'b1;
    repeat (2) cycle();
    enable = 1'b1;
    repeat (20) cycle();
    n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL midreset_buffered: tready got %b want 0", s_axis_tready); end
    reset = 1'b1; s_axis_tdata = 16'h8000;
    cycle();
    n_cmp++; if ({s_axis_tready, pdm_clk, pdm_out, sample_strobe, underrun} !== 5'b0) begin
      n_bad++; $display("FAIL midreset_outputs: got %b want 00000", {s_axis_tready, pdm_clk, pdm_out, sample_strobe, underrun});
    end
    reset = 1'b0;
    clear_mon();
    repeat (40) cycle();
    bad = 0;
    for (int i = 0; i < 8; i++) if (bits[i] !== 1'b0) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL midreset_bits: %0d bits wrong, want 0", bad); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL midreset_underrun: got %b want 0", underrun); end
    enable = 1'b0; s_axis_tvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    test_reset();
    test_midscale();
    test_density();
    test_back_to_back();
    test_underrun();
    test_enable_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdm_stream_tx.md
Name: pdm_stream_tx

Overview:
- Pulse-density-modulation transmitter for the AXI FIFO PDM stream path.
- Consumes signed PCM samples from an AXI-Stream FIFO (slave side).
- Drives a 1-bit PDM line plus a bit clock derived from the fabric clock by an integer divider.
- Sink-direction counterpart of the stream path: converts FIFO data back into a slow-rate serial output using a first-order modulator.

Parameters:
DATA_W, 16, PCM sample width (two's complement)
CLK_DIV, 50, clk cycles per PDM bit (>=2, even)
OSR, 64, PDM bits per PCM sample (>=2)

Ports:
clk  input  1  fabric clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  run control; low = modulator idle
s_axis_tdata  input  DATA_W  signed PCM sample
s_axis_tvalid  input  1  sample valid
s_axis_tready  output  1  sample accepted when tvalid && tready
pdm_clk  output  1  PDM bit clock, registered
pdm_out  output  1  PDM data, registered, changes with pdm_clk rising
sample_strobe  output  1  1-cycle pulse when a new sample is loaded into the modulator
underrun  output  1  sticky: sample boundary reached with no sample buffered

Behaviour:
- Reset values: all outputs 0; internal counters, accumulator, holding register and current sample cleared to 0.
- s_axis_tready:
  - Registered; equals NOT hold_valid (one-entry holding buffer).
  - First 1 appears the cycle after reset deasserts.
  - Not gated by enable, so the buffer can prefill while idle.
- Handshake:
  - tvalid && tready loads s_axis_tdata into the holding register; hold_valid=1 and tready=0 the next cycle.
  - tdata is sampled only on handshake.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while enable=1, then wraps.
  - tick = enable && div_cnt==CLK_DIV-1.
- pdm_clk: set to 1 on the cycle after tick; cleared to 0 on the cycle after div_cnt==CLK_DIV/2-1. 50% duty.
- Bit counter: bit_cnt counts 0..OSR-1, advances on each tick, wraps to 0.
- Sample load (tick with bit_cnt==0):
  - If hold_valid: eff = hold, cur <= hold, hold_valid cleared, sample_strobe=1 next cycle.
  - Otherwise: eff = 0 (midscale), cur <= 0, underrun set. sample_strobe still pulses.
  - On ticks with bit_cnt!=0: eff = cur.
- Modulator (evaluated on every tick):
  - u = eff with MSB inverted (offset binary, DATA_W bits).
  - sum = acc + u, DATA_W+1 bits unsigned.
  - pdm_out <= sum[DATA_W]; acc <= sum[DATA_W-1:0].
  - Ones density = u / 2^DATA_W.
  - No saturation is needed; the carry is the output bit.
- Latency:
  - An accepted sample first affects pdm_out at the next bit_cnt==0 tick.
  - pdm_out is valid 1 clk after tick.
- enable=0:
  - div_cnt, bit_cnt and acc are held at 0; pdm_clk=0 and pdm_out=0 from the next cycle.
  - cur is retained; the holding buffer and tready keep operating.
  - Re-enable restarts cleanly at bit_cnt=0 (a load boundary).
- enable dropped mid-sample: partial sample discarded; cur is not reloaded until the next bit_cnt==0 tick.
- underrun: cleared only by reset. Not set while enable=0.
- Reset mid-operation: everything returns to reset values on the next edge. Any buffered sample is lost.
- Handshake cycle coinciding with a load boundary: impossible to conflict. tready=1 implies hold_valid=0, so that load takes midscale and flags underrun; the new sample waits for the next boundary.

Test Plan:
- Reset then idle: reset=1 for 3 cycles -> all outputs 0; s_axis_tready=1 on the 2nd cycle after release; pdm_clk stays 0 while enable=0.
- Midscale tone: CLK_DIV=4, OSR=8, feed 0x0000 continuously, enable=1 -> pdm_clk period 4 clk; pdm_out 0,1,0,1...; one sample_strobe per 32 clk; underrun=0.
- Density check: feed 0x4000 (u=0xC000) -> exactly 3 ones per 4 bits after the first bit; feed 0x8000 -> pdm_out constant 0; feed 0x7FFF -> at most 1 zero in 64 bits.
- Backpressure: tvalid held 1 with incrementing data -> exactly one handshake per sample period; tready low between loads; no sample skipped or duplicated.
- Underrun: stop tvalid after 2 samples -> underrun rises at the 3rd boundary and stays 1; density reverts to 1/2; resuming tvalid does not clear it; reset clears it.
- Enable/reset mid-sample: drop enable at bit_cnt=3 -> pdm_clk and pdm_out go to 0; re-enable -> sample_strobe at the first tick. Assert reset mid-stream -> buffered sample dropped, next output derives from new input only.
